// File: rtl/crank_wheel_gen_pkg.sv
// Shared types and arithmetic for crank-wheel stimulus generators.
package crank_wheel_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_GAP
  } state_t;

  // Callers zero-extend unsigned periods and sign-extend the step to SAT_W bits.
  localparam int SAT_W = 48;

  function automatic logic [SAT_W-1:0] sat_add(
    input logic [SAT_W-1:0] cur,
    input logic [SAT_W-1:0] step,
    input logic [SAT_W-1:0] lo,
    input logic [SAT_W-1:0] hi
  );
    logic signed [SAT_W+1:0] sum;
    sum = $signed({2'b00, cur}) + $signed({{2{step[SAT_W-1]}}, step});
    if (sum < $signed({2'b00, lo})) return lo;
    if (sum > $signed({2'b00, hi})) return hi;
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/crank_period_ramp.sv
// Running tooth period: clamped load at revolution start, saturating step per tooth.
module crank_period_ramp
  import crank_wheel_gen_pkg::*;
#(
  parameter int PER_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step_en,
  input  logic [PER_W-1:0] init_period,
  input  logic [PER_W-1:0] init_min,
  input  logic [PER_W-1:0] init_max,
  input  logic [PER_W-1:0] step,
  input  logic [PER_W-1:0] per_min,
  input  logic [PER_W-1:0] per_max,
  output logic [PER_W-1:0] cur_period,
  output logic [PER_W-1:0] load_period,
  output logic [PER_W-1:0] step_period
);

  localparam int PAD = SAT_W - PER_W;

  function automatic logic [SAT_W-1:0] zx(input logic [PER_W-1:0] v);
    return {{PAD{1'b0}}, v};
  endfunction

  function automatic logic [SAT_W-1:0] sx(input logic [PER_W-1:0] v);
    return {{PAD{v[PER_W-1]}}, v};
  endfunction

  // Candidates are exposed so the caller can size the next phase in the same cycle.
  assign load_period = PER_W'(sat_add(zx(init_period), '0, zx(init_min), zx(init_max)));
  assign step_period = PER_W'(sat_add(zx(cur_period), sx(step), zx(per_min), zx(per_max)));

  always_ff @(posedge clk) begin
    if (!rst)         cur_period <= '0;
    else if (load)    cur_period <= load_period;
    else if (step_en) cur_period <= step_period;
  end

endmodule

// File: rtl/crank_wheel_gen.sv
// Trigger-wheel emulator: square tooth train with missing-tooth gap and period ramp.
module crank_wheel_gen
  import crank_wheel_gen_pkg::*;
#(
  parameter int PER_W = 24,
  parameter int TH_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [PER_W-1:0] cfg_period,
  input  logic [PER_W-1:0] cfg_step,
  input  logic [PER_W-1:0] cfg_per_min,
  input  logic [PER_W-1:0] cfg_per_max,
  input  logic [TH_W-1:0]  cfg_teeth,
  input  logic [TH_W-1:0]  cfg_missing,
  output logic             vr_out,
  output logic [TH_W-1:0]  tooth_idx,
  output logic             rev_pulse,
  output logic             gap_active,
  output logic [PER_W-1:0] cur_period,
  output logic             cfg_err
);

  state_t           state, state_nxt;
  logic [PER_W-1:0] cnt, cnt_nxt;
  logic [TH_W-1:0]  idx_nxt, idx_inc, gap_start;
  logic             rev_nxt, err_nxt;
  logic             latch, ld, stp, cfg_ok, last_pos;
  logic [PER_W-1:0] sh_step, sh_min, sh_max;
  logic [TH_W-1:0]  sh_teeth, sh_missing;
  logic [PER_W-1:0] load_period, step_period;

  assign cfg_ok = ({1'b0, cfg_teeth} >= ({1'b0, cfg_missing} + (TH_W+1)'(2)))
               && (cfg_missing != '0)
               && (cfg_period  >= PER_W'(2))
               && (cfg_per_min >= PER_W'(2))
               && (cfg_per_min <= cfg_per_max);

  assign idx_inc    = tooth_idx + TH_W'(1);
  assign gap_start  = sh_teeth - sh_missing;
  assign last_pos   = (tooth_idx == sh_teeth - TH_W'(1));
  assign vr_out     = (state == ST_HI);
  assign gap_active = (state == ST_GAP);

  crank_period_ramp #(.PER_W(PER_W)) u_ramp (
    .clk        (clk),
    .rst        (rst),
    .load       (ld),
    .step_en    (stp),
    .init_period(cfg_period),
    .init_min   (cfg_per_min),
    .init_max   (cfg_per_max),
    .step       (sh_step),
    .per_min    (sh_min),
    .per_max    (sh_max),
    .cur_period (cur_period),
    .load_period(load_period),
    .step_period(step_period)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      tooth_idx  <= '0;
      rev_pulse  <= 1'b0;
      cfg_err    <= 1'b0;
      sh_step    <= '0;
      sh_min     <= '0;
      sh_max     <= '0;
      sh_teeth   <= '0;
      sh_missing <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tooth_idx <= idx_nxt;
      rev_pulse <= rev_nxt;
      cfg_err   <= err_nxt;
      if (latch) begin
        sh_step    <= cfg_step;
        sh_min     <= cfg_per_min;
        sh_max     <= cfg_per_max;
        sh_teeth   <= cfg_teeth;
        sh_missing <= cfg_missing;
      end
    end
  end

  // Tooth boundaries only occur at the end of LO or of a gap position, so ena
  // and config reloads never truncate a high phase.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = tooth_idx;
    rev_nxt   = 1'b0;
    err_nxt   = cfg_err;
    latch     = 1'b0;
    ld        = 1'b0;
    stp       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ena) begin
          if (cfg_ok) begin
            state_nxt = ST_HI;
            latch     = 1'b1;
            ld        = 1'b1;
            idx_nxt   = '0;
            rev_nxt   = 1'b1;
            err_nxt   = 1'b0;
            cnt_nxt   = (load_period >> 1) - PER_W'(1);
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_HI: begin
        if (cnt == '0) begin
          state_nxt = ST_LO;
          cnt_nxt   = cur_period - (cur_period >> 1) - PER_W'(1);
        end else begin
          cnt_nxt = cnt - PER_W'(1);
        end
      end
      default: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - PER_W'(1);
        end else if (!ena) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end else if (state == ST_GAP && last_pos) begin
          idx_nxt = '0;
          if (cfg_ok) begin
            state_nxt = ST_HI;
            latch     = 1'b1;
            ld        = 1'b1;
            rev_nxt   = 1'b1;
            cnt_nxt   = (load_period >> 1) - PER_W'(1);
          end else begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
          end
        end else begin
          stp     = 1'b1;
          idx_nxt = idx_inc;
          if (state == ST_GAP || idx_inc == gap_start) begin
            state_nxt = ST_GAP;
            cnt_nxt   = step_period - PER_W'(1);
          end else begin
            state_nxt = ST_HI;
            cnt_nxt   = (step_period >> 1) - PER_W'(1);
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Self-checking bench for crank_wheel_gen against a tooth-level waveform model.
module tb_crank_wheel_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic [23:0] cfg_period = '0, cfg_step = '0, cfg_per_min = '0, cfg_per_max = '0;
  logic [7:0]  cfg_teeth = '0, cfg_missing = '0;
  logic        vr_out, rev_pulse, gap_active, cfg_err;
  logic [7:0]  tooth_idx;
  logic [23:0] cur_period;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit vr;
    bit gap;
    bit rev;
    int idx;
    int per;
  } exp_t;

  exp_t exp_q[$];

  crank_wheel_gen #(.PER_W(24), .TH_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .cfg_period(cfg_period), .cfg_step(cfg_step),
    .cfg_per_min(cfg_per_min), .cfg_per_max(cfg_per_max),
    .cfg_teeth(cfg_teeth), .cfg_missing(cfg_missing),
    .vr_out(vr_out), .tooth_idx(tooth_idx), .rev_pulse(rev_pulse),
    .gap_active(gap_active), .cur_period(cur_period), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Expected waveform, one entry per cycle from the first cycle after ena is
  // sampled; revolutions after the first use period2 as the restart period.
  task automatic build_model(input int period, input int period2, input int step,
                             input int pmin, input int pmax, input int teeth,
                             input int missing, input int ncyc);
    int p, idx, hi;
    bit gap;
    exp_t e;
    exp_q.delete();
    p = clampi(period, pmin, pmax);
    idx = 0;
    while (exp_q.size() < ncyc) begin
      gap = (idx >= teeth - missing);
      hi = gap ? 0 : p / 2;
      for (int c = 0; c < p; c++) begin
        e.vr = (c < hi); e.gap = gap; e.rev = (idx == 0 && c == 0);
        e.idx = idx; e.per = p;
        exp_q.push_back(e);
      end
      idx++;
      if (idx == teeth) begin
        idx = 0;
        p = clampi(period2, pmin, pmax);
      end else begin
        p = clampi(p + step, pmin, pmax);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ena = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic start_run(input int period, input int step, input int pmin,
                           input int pmax, input int teeth, input int missing);
    cfg_period  = 24'(period);
    cfg_step    = 24'(step);
    cfg_per_min = 24'(pmin);
    cfg_per_max = 24'(pmax);
    cfg_teeth   = 8'(teeth);
    cfg_missing = 8'(missing);
    ena = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ena = 1'b1;
    cfg_period = 24'd100; cfg_per_min = 24'd2; cfg_per_max = 24'd1000;
    cfg_teeth = 8'd60; cfg_missing = 8'd2;
    repeat (3) @(negedge clk);
    checks++; if (vr_out !== 1'b0) begin failures++; $display("FAIL reset_vr got=%b exp=0", vr_out); end
    checks++; if (tooth_idx !== 8'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", tooth_idx); end
    checks++; if (rev_pulse !== 1'b0) begin failures++; $display("FAIL reset_rev got=%b exp=0", rev_pulse); end
    checks++; if (gap_active !== 1'b0) begin failures++; $display("FAIL reset_gap got=%b exp=0", gap_active); end
    checks++; if (cur_period !== 24'd0) begin failures++; $display("FAIL reset_per got=%0d exp=0", cur_period); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    ena = 1'b0;
  endtask

  task automatic test_profiles();
    int t_per[5]  = '{100, 101, 1000, 300, 150};
    int t_step[5] = '{0, 0, -10, -10, 10};
    int t_min[5]  = '{2, 2, 500, 200, 100};
    int t_max[5]  = '{1000, 1000, 2000, 2000, 200};
    int t_th[5]   = '{60, 36, 60, 20, 10};
    int t_ms[5]   = '{2, 1, 2, 2, 1};
    int t_n[5]    = '{12100, 4000, 12000, 5000, 4000};
    exp_t e;
    for (int t = 0; t < 5; t++) begin
      build_model(t_per[t], t_per[t], t_step[t], t_min[t], t_max[t], t_th[t], t_ms[t], t_n[t]);
      do_reset();
      start_run(t_per[t], t_step[t], t_min[t], t_max[t], t_th[t], t_ms[t]);
      for (int k = 0; k < t_n[t]; k++) begin
        e = exp_q[k];
        checks++;
        if ({vr_out, gap_active, rev_pulse, tooth_idx, cur_period} !== {e.vr, e.gap, e.rev, 8'(e.idx), 24'(e.per)}) begin
          failures++;
          $display("FAIL profile%0d cyc=%0d got vr=%b gap=%b rev=%b idx=%0d per=%0d exp vr=%b gap=%b rev=%b idx=%0d per=%0d",
                   t, k, vr_out, gap_active, rev_pulse, tooth_idx, cur_period, e.vr, e.gap, e.rev, e.idx, e.per);
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_cfg_err();
    do_reset();
    start_run(100, 0, 2, 1000, 3, 2);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (cfg_err !== 1'b1 || vr_out !== 1'b0) begin
        failures++;
        $display("FAIL cfg_err_hold cyc=%0d got err=%b vr=%b exp err=1 vr=0", k, cfg_err, vr_out);
        break;
      end
      @(negedge clk);
    end
    cfg_teeth = 8'd36;
    cfg_missing = 8'd1;
    @(negedge clk);
    checks++;
    if ({cfg_err, vr_out, rev_pulse, cur_period} !== {1'b0, 1'b1, 1'b1, 24'd100}) begin
      failures++;
      $display("FAIL cfg_err_clear got err=%b vr=%b rev=%b per=%0d exp err=0 vr=1 rev=1 per=100",
               cfg_err, vr_out, rev_pulse, cur_period);
    end
  endtask

  task automatic test_ena_drop();
    exp_t e;
    build_model(100, 100, 0, 2, 1000, 60, 2, 1100);
    do_reset();
    start_run(100, 0, 2, 1000, 60, 2);
    for (int k = 0; k < 1300; k++) begin
      if (k < 1100) begin
        e = exp_q[k];
        checks++;
        if ({vr_out, tooth_idx, cur_period} !== {e.vr, 8'(e.idx), 24'(e.per)}) begin
          failures++;
          $display("FAIL ena_drop_finish cyc=%0d got vr=%b idx=%0d per=%0d exp vr=%b idx=%0d per=%0d",
                   k, vr_out, tooth_idx, cur_period, e.vr, e.idx, e.per);
          break;
        end
      end else begin
        checks++;
        if (vr_out !== 1'b0 || gap_active !== 1'b0) begin
          failures++;
          $display("FAIL ena_drop_idle cyc=%0d got vr=%b gap=%b exp vr=0 gap=0", k, vr_out, gap_active);
          break;
        end
      end
      if (k == 1020) ena = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_midrev_cfg();
    exp_t e;
    build_model(100, 80, 0, 2, 1000, 60, 2, 9000);
    do_reset();
    start_run(100, 0, 2, 1000, 60, 2);
    for (int k = 0; k < 9000; k++) begin
      e = exp_q[k];
      checks++;
      if ({vr_out, gap_active, rev_pulse, tooth_idx, cur_period} !== {e.vr, e.gap, e.rev, 8'(e.idx), 24'(e.per)}) begin
        failures++;
        $display("FAIL midrev_cfg cyc=%0d got vr=%b gap=%b rev=%b idx=%0d per=%0d exp vr=%b gap=%b rev=%b idx=%0d per=%0d",
                 k, vr_out, gap_active, rev_pulse, tooth_idx, cur_period, e.vr, e.gap, e.rev, e.idx, e.per);
        break;
      end
      if (k == 3000) cfg_period = 24'd80;
      @(negedge clk);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    start_run(100, 0, 2, 1000, 60, 2);
    repeat (1010) @(negedge clk);
    checks++;
    if (vr_out !== 1'b1 || tooth_idx !== 8'd10) begin
      failures++;
      $display("FAIL rst_mid_pre got vr=%b idx=%0d exp vr=1 idx=10", vr_out, tooth_idx);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({vr_out, tooth_idx, rev_pulse, gap_active, cur_period, cfg_err} !== 35'd0) begin
      failures++;
      $display("FAIL rst_mid got vr=%b idx=%0d rev=%b gap=%b per=%0d err=%b exp all 0",
               vr_out, tooth_idx, rev_pulse, gap_active, cur_period, cfg_err);
    end
  endtask

  task automatic test_random();
    int per, stp, pmin, pmax, th, ms;
    exp_t e;
    for (int r = 0; r < 4; r++) begin
      pmin = int'($urandom_range(20, 2));
      pmax = pmin + int'($urandom_range(60, 0));
      per  = int'($urandom_range(90, 2));
      stp  = int'($urandom_range(20, 0)) - 10;
      th   = int'($urandom_range(16, 3));
      ms   = int'($urandom_range(th - 2, 1));
      build_model(per, per, stp, pmin, pmax, th, ms, 1500);
      do_reset();
      start_run(per, stp, pmin, pmax, th, ms);
      for (int k = 0; k < 1500; k++) begin
        e = exp_q[k];
        checks++;
        if ({vr_out, gap_active, rev_pulse, tooth_idx, cur_period} !== {e.vr, e.gap, e.rev, 8'(e.idx), 24'(e.per)}) begin
          failures++;
          $display("FAIL random%0d (per=%0d step=%0d min=%0d max=%0d teeth=%0d miss=%0d) cyc=%0d got vr=%b gap=%b rev=%b idx=%0d per=%0d exp vr=%b gap=%b rev=%b idx=%0d per=%0d",
                   r, per, stp, pmin, pmax, th, ms, k, vr_out, gap_active, rev_pulse, tooth_idx, cur_period,
                   e.vr, e.gap, e.rev, e.idx, e.per);
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_profiles();
    test_cfg_err();
    test_ena_drop();
    test_midrev_cfg();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crank_wheel_gen.md
Name: crank_wheel_gen

Overview:
- Synthesizable trigger-wheel emulator. It generates the toothed crank signal that the angle generator's VR capture path consumes, i.e. the transmit side of that interface.
- Produces a square tooth train with a configurable missing-tooth gap (e.g. 60-2), constant or linearly ramping tooth period.
- Used on-chip for loopback self-test of the angle generator (drives its vr_in) and for bench stimulus.

Parameters:
- PER_W, 24, width of tooth period / step values in clk cycles (matches period capture width)
- TH_W, 8, width of tooth-count fields (matches tooth counter width)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- ena  in  1  run request; sampled every cycle
- cfg_period  in  PER_W  initial tooth period in clk cycles (tooth pitch incl. missing-tooth positions)
- cfg_step  in  PER_W  signed two's-complement period increment applied at each tooth boundary (0 = constant speed)
- cfg_per_min  in  PER_W  lower saturation limit for running period
- cfg_per_max  in  PER_W  upper saturation limit for running period
- cfg_teeth  in  TH_W  total tooth positions per revolution incl. missing (e.g. 60)
- cfg_missing  in  TH_W  missing tooth count (e.g. 2)
- vr_out  out  1  emulated sensor signal, high = tooth
- tooth_idx  out  TH_W  current tooth position, 0..cfg_teeth-1
- rev_pulse  out  1  one-cycle strobe at rising edge of tooth 0
- gap_active  out  1  high while in missing-tooth gap positions
- cur_period  out  PER_W  running period in effect for current tooth
- cfg_err  out  1  configuration rejected

Behaviour:
- Reset (rst=0 at clk edge): all outputs 0; FSM to IDLE; shadow config cleared.
- FSM states: IDLE, HI, LO, GAP.
- IDLE → HI when ena=1 and config valid. Config valid: cfg_teeth ≥ cfg_missing+2, cfg_missing ≥ 1, cfg_period ≥ 2, cfg_per_min ≥ 2, cfg_per_min ≤ cfg_per_max.
  - On entry: shadow-latch all cfg_*; cur_period = clamp(cfg_period); tooth_idx=0; vr_out=1 on the cycle after ena is sampled high (1-cycle latency); rev_pulse=1 for that cycle.
  - Invalid config with ena=1: stay IDLE, cfg_err=1, held until a valid config is seen with ena=1.
- HI: vr_out=1 for hi_len = cur_period>>1 cycles, then → LO.
- LO: vr_out=0 for lo_len = cur_period - hi_len cycles (odd period puts the extra cycle in LO).
- At LO end (tooth boundary):
  - Update cur_period = sat(cur_period + cfg_step, per_min, per_max), with full-width signed add and no wrap.
  - tooth_idx+1.
  - If new idx = cfg_teeth - cfg_missing → GAP; else → HI.
- GAP: vr_out=0 for cfg_missing periods. tooth_idx advances at each period boundary, gap_active=1, cur_period stepped per position.
  - After the last gap position: tooth_idx wraps to 0, → HI, rev_pulse=1.
- Tooth-boundary rules:
  - Shadow config reloads only at tooth 0 boundary; changes mid-revolution are ignored until then.
  - A reload that is invalid → IDLE, cfg_err=1.
  - ena=0 is honoured only at a tooth boundary (end of LO or a gap position): → IDLE with vr_out=0. No runt pulses are ever emitted.
- rst=0 mid-tooth: immediate return to reset values on that edge; vr_out drops the same cycle.
- Internal cycle counter: PER_W bits, counts down from length-1, terminal at 0. No counter wrap is possible because lengths are ≥ 1.

Decomposition:
- Shared package: FSM state enum (IDLE/HI/LO/GAP) and a saturating signed-add function, reused by future speed-profile blocks.
- One sub-module: crank_period_ramp (holds cur_period, applies step with saturation on a strobe).
- FSM, phase counter and tooth counter stay in the top module.

Test Plan:
- Period=100, teeth=60, missing=2, step=0, ena=1 → vr_out high 50 / low 50 per tooth; final low run 250 cycles; rev_pulse every 6000 cycles; tooth_idx 58,59 with gap_active=1.
- Period=101 → high 50, low 51; cur_period stays 101.
- Period=1000, step=-10, min=500, max=2000 → tooth n period = 1000-10n until clamped at 500; never below 500; step=+10 saturates at 2000.
- cfg_teeth=3, missing=2 with ena=1 → cfg_err=1, vr_out stays 0; then teeth=36, missing=1 → runs, cfg_err clears on start.
- Drop ena mid-HI of tooth 10 → tooth finishes its full 50/50, then IDLE with vr_out=0. Change cfg_period mid-revolution → takes effect at next tooth 0 only.
- Assert rst=0 mid-HI → next cycle all outputs 0. Loopback vr_out into the angle generator with filter off, 60-2 → generator start flag asserts after gap detection.
